// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle: decode allocation, dispatch operand query,
// ALU/LSB result broadcast, and commit/flush outputs.
interface reorder_buffer_if #(
    parameter int ROB_AW = 4
);
    logic              alloc_valid;
    logic [4:0]        alloc_rd;
    logic              alloc_wb;
    logic              alloc_store;
    logic              alloc_branch;
    logic              rob_full;
    logic [ROB_AW-1:0] alloc_tag;

    logic [ROB_AW-1:0] q1_tag;
    logic [ROB_AW-1:0] q2_tag;
    logic              q1_ready;
    logic              q2_ready;
    logic [31:0]       q1_val;
    logic [31:0]       q2_val;

    logic              alu_flag;
    logic [ROB_AW-1:0] alu_reorder;
    logic [31:0]       alu_val;
    logic              alu_mispredict;
    logic [31:0]       alu_target;
    logic              lsb_flag;
    logic [ROB_AW-1:0] lsb_reorder;
    logic [31:0]       lsb_val;

    logic              commit_valid;
    logic [ROB_AW-1:0] commit_tag;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_val;
    logic              commit_wb;
    logic              commit_store;
    logic              flush;
    logic [31:0]       flush_pc;

    modport master (
        output alloc_valid, alloc_rd, alloc_wb, alloc_store, alloc_branch,
        input  rob_full, alloc_tag,
        output q1_tag, q2_tag,
        input  q1_ready, q2_ready, q1_val, q2_val,
        output alu_flag, alu_reorder, alu_val, alu_mispredict, alu_target,
        output lsb_flag, lsb_reorder, lsb_val,
        input  commit_valid, commit_tag, commit_rd, commit_val, commit_wb,
        input  commit_store, flush, flush_pc
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_wb, alloc_store, alloc_branch,
        output rob_full, alloc_tag,
        input  q1_tag, q2_tag,
        output q1_ready, q2_ready, q1_val, q2_val,
        input  alu_flag, alu_reorder, alu_val, alu_mispredict, alu_target,
        input  lsb_flag, lsb_reorder, lsb_val,
        output commit_valid, commit_tag, commit_rd, commit_val, commit_wb,
        output commit_store, flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer with one commit per cycle and flush on a
// mispredicted branch. Define ROB_BYPASS_EN to forward same-cycle results to queries.
module reorder_buffer #(
    parameter int ROB_AW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << ROB_AW;
    typedef logic [ROB_AW-1:0] ptr_t;
    typedef logic [ROB_AW:0]   cnt_t;

    ptr_t head_q, head_d, tail_q, tail_d;
    cnt_t count_q, count_d;
    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;

    logic [4:0]  rd_q [DEPTH];
    logic [4:0]  rd_d [DEPTH];
    logic        wb_q [DEPTH];
    logic        wb_d [DEPTH];
    logic        store_q [DEPTH];
    logic        store_d [DEPTH];
    logic        branch_q [DEPTH];
    logic        branch_d [DEPTH];
    logic        mispredict_q [DEPTH];
    logic        mispredict_d [DEPTH];
    logic [31:0] target_q [DEPTH];
    logic [31:0] target_d [DEPTH];
    logic [31:0] val_q [DEPTH];
    logic [31:0] val_d [DEPTH];

    logic        commit_valid_q, commit_valid_d;
    ptr_t        commit_tag_q, commit_tag_d;
    logic [4:0]  commit_rd_q, commit_rd_d;
    logic [31:0] commit_val_q, commit_val_d;
    logic        commit_wb_q, commit_wb_d;
    logic        commit_store_q, commit_store_d;
    logic        flush_q, flush_d;
    logic [31:0] flush_pc_q, flush_pc_d;

    logic full, do_commit, do_alloc, do_flush;

    assign full          = (count_q == cnt_t'(DEPTH));
    assign rob.rob_full  = full;
    assign rob.alloc_tag = tail_q;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        rd_d           = rd_q;
        wb_d           = wb_q;
        store_d        = store_q;
        branch_d       = branch_q;
        mispredict_d   = mispredict_q;
        target_d       = target_q;
        val_d          = val_q;
        commit_valid_d = 1'b0;
        commit_tag_d   = commit_tag_q;
        commit_rd_d    = commit_rd_q;
        commit_val_d   = commit_val_q;
        commit_wb_d    = commit_wb_q;
        commit_store_d = commit_store_q;
        flush_d        = 1'b0;
        flush_pc_d     = flush_pc_q;
        do_commit      = 1'b0;
        do_alloc       = 1'b0;
        do_flush       = 1'b0;

        if (rdy) begin
            do_commit = busy_q[head_q] && ready_q[head_q];
            do_alloc  = rob.alloc_valid && !full;
            do_flush  = do_commit && branch_q[head_q] && mispredict_q[head_q];

            // LSB first so an ALU write to the same tag overrides it
            if (rob.lsb_flag && busy_q[rob.lsb_reorder] && !ready_q[rob.lsb_reorder]) begin
                val_d[rob.lsb_reorder]   = rob.lsb_val;
                ready_d[rob.lsb_reorder] = 1'b1;
            end
            if (rob.alu_flag && busy_q[rob.alu_reorder] && !ready_q[rob.alu_reorder]) begin
                val_d[rob.alu_reorder]        = rob.alu_val;
                mispredict_d[rob.alu_reorder] = rob.alu_mispredict;
                target_d[rob.alu_reorder]     = rob.alu_target;
                ready_d[rob.alu_reorder]      = 1'b1;
            end

            if (do_commit) begin
                commit_valid_d   = 1'b1;
                commit_tag_d     = head_q;
                commit_rd_d      = rd_q[head_q];
                commit_val_d     = val_q[head_q];
                commit_wb_d      = wb_q[head_q];
                commit_store_d   = store_q[head_q];
                busy_d[head_q]   = 1'b0;
                head_d           = head_q + ptr_t'(1);
            end

            if (do_alloc) begin
                busy_d[tail_q]       = 1'b1;
                ready_d[tail_q]      = 1'b0;
                rd_d[tail_q]         = rob.alloc_rd;
                wb_d[tail_q]         = rob.alloc_wb;
                store_d[tail_q]      = rob.alloc_store;
                branch_d[tail_q]     = rob.alloc_branch;
                mispredict_d[tail_q] = 1'b0;
                tail_d               = tail_q + ptr_t'(1);
            end

            if (do_alloc && !do_commit) begin
                count_d = count_q + cnt_t'(1);
            end else if (!do_alloc && do_commit) begin
                count_d = count_q - cnt_t'(1);
            end

            // Flush discards this cycle's allocation and writebacks via busy clear
            if (do_flush) begin
                flush_d    = 1'b1;
                flush_pc_d = target_q[head_q];
                busy_d     = '0;
                ready_d    = '0;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_wb_q    <= 1'b0;
            commit_store_q <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_valid_q <= commit_valid_d;
            commit_tag_q   <= commit_tag_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_wb_q    <= commit_wb_d;
            commit_store_q <= commit_store_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Entry payload needs no reset: busy/ready gate every use of it
    always_ff @(posedge clk) begin
        rd_q         <= rd_d;
        wb_q         <= wb_d;
        store_q      <= store_d;
        branch_q     <= branch_d;
        mispredict_q <= mispredict_d;
        target_q     <= target_d;
        val_q        <= val_d;
    end

    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_tag   = commit_tag_q;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_val   = commit_val_q;
    assign rob.commit_wb    = commit_wb_q;
    assign rob.commit_store = commit_store_q;
    assign rob.flush        = flush_q;
    assign rob.flush_pc     = flush_pc_q;

    ptr_t q_tag [2];
    assign q_tag[0] = rob.q1_tag;
    assign q_tag[1] = rob.q2_tag;

    for (genvar gi = 0; gi < 2; gi++) begin : g_query
        logic        q_ready;
        logic [31:0] q_val;
        always_comb begin
            q_ready = busy_q[q_tag[gi]] && ready_q[q_tag[gi]];
            q_val   = val_q[q_tag[gi]];
`ifdef ROB_BYPASS_EN
            if (busy_q[q_tag[gi]]) begin
                if (rob.alu_flag && rob.alu_reorder == q_tag[gi]) begin
                    q_ready = 1'b1;
                    q_val   = rob.alu_val;
                end else if (rob.lsb_flag && rob.lsb_reorder == q_tag[gi]) begin
                    q_ready = 1'b1;
                    q_val   = rob.lsb_val;
                end
            end
`endif
        end
    end

    assign rob.q1_ready = g_query[0].q_ready;
    assign rob.q1_val   = g_query[0].q_val;
    assign rob.q2_ready = g_query[1].q_ready;
    assign rob.q2_val   = g_query[1].q_val;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; expectations follow the
// ROB_BYPASS_EN setting of the build.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    reorder_buffer_if #(.ROB_AW(4)) bus ();

    reorder_buffer #(.ROB_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rob (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid    = 1'b0;
        bus.alloc_rd       = 5'd0;
        bus.alloc_wb       = 1'b0;
        bus.alloc_store    = 1'b0;
        bus.alloc_branch   = 1'b0;
        bus.q1_tag         = 4'd0;
        bus.q2_tag         = 4'd0;
        bus.alu_flag       = 1'b0;
        bus.alu_reorder    = 4'd0;
        bus.alu_val        = 32'd0;
        bus.alu_mispredict = 1'b0;
        bus.alu_target     = 32'd0;
        bus.lsb_flag       = 1'b0;
        bus.lsb_reorder    = 4'd0;
        bus.lsb_val        = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic wb, input logic st, input logic br);
        bus.alloc_valid  = 1'b1;
        bus.alloc_rd     = rd;
        bus.alloc_wb     = wb;
        bus.alloc_store  = st;
        bus.alloc_branch = br;
        tick();
        idle();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_full", bus.rob_full, 0);
        check("rst_tag", bus.alloc_tag, 0);
        check("rst_cvalid", bus.commit_valid, 0);
        check("rst_ctag", bus.commit_tag, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_flush_pc", bus.flush_pc, 0);
        check("rst_q1_ready", bus.q1_ready, 0);

        // Fill all 16 entries; tags run 0..15
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill_tag%0d", i), bus.alloc_tag, i);
            check($sformatf("fill_full%0d", i), bus.rob_full, 0);
            alloc(i[4:0], 1'b1, 1'b0, 1'b0);
        end
        check("full_after16", bus.rob_full, 1);
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 5'd31;
        tick();
        check("drop17_tag", bus.alloc_tag, 0);
        check("drop17_full", bus.rob_full, 1);

        // Full buffer: make head ready, then commit while alloc_valid held
        bus.alu_flag = 1'b1; bus.alu_reorder = 4'd0; bus.alu_val = 32'h77;
        tick();
        check("fullc_ready_cvalid", bus.commit_valid, 0);
        bus.alu_flag = 1'b0;
        bus.alloc_rd = 5'd20;
        tick();
        check("fullc_cvalid", bus.commit_valid, 1);
        check("fullc_ctag", bus.commit_tag, 0);
        check("fullc_cval", bus.commit_val, 32'h77);
        check("fullc_crd", bus.commit_rd, 0);
        check("fullc_cwb", bus.commit_wb, 1);
        check("fullc_full_cnt15", bus.rob_full, 0);
        check("fullc_tag_nochange", bus.alloc_tag, 0);
        tick();
        check("wrap_alloc_tag", bus.alloc_tag, 1);
        check("wrap_full", bus.rob_full, 1);
        check("wrap_cvalid", bus.commit_valid, 0);
        idle();

        // In-order commit: tag 1 ready before tag 0
        do_reset();
        alloc(5'd3, 1'b1, 1'b0, 1'b0);
        alloc(5'd4, 1'b1, 1'b0, 1'b0);
        bus.lsb_flag = 1'b1; bus.lsb_reorder = 4'd1; bus.lsb_val = 32'h55;
        tick();
        idle();
        check("order_no_early", bus.commit_valid, 0);
        bus.alu_flag = 1'b1; bus.alu_reorder = 4'd0; bus.alu_val = 32'h11;
        tick();
        idle();
        check("order_wait", bus.commit_valid, 0);
        tick();
        check("order_c0_valid", bus.commit_valid, 1);
        check("order_c0_tag", bus.commit_tag, 0);
        check("order_c0_val", bus.commit_val, 32'h11);
        check("order_c0_rd", bus.commit_rd, 3);
        tick();
        check("order_c1_valid", bus.commit_valid, 1);
        check("order_c1_tag", bus.commit_tag, 1);
        check("order_c1_val", bus.commit_val, 32'h55);
        check("order_c1_rd", bus.commit_rd, 4);
        tick();
        check("order_idle", bus.commit_valid, 0);

        // Same tag on both buses: ALU wins; store with no register write
        alloc(5'd9, 1'b0, 1'b1, 1'b0);
        bus.alu_flag = 1'b1; bus.alu_reorder = 4'd2; bus.alu_val = 32'hAA;
        bus.lsb_flag = 1'b1; bus.lsb_reorder = 4'd2; bus.lsb_val = 32'hBB;
        tick();
        idle();
        tick();
        check("prio_cvalid", bus.commit_valid, 1);
        check("prio_ctag", bus.commit_tag, 2);
        check("prio_cval", bus.commit_val, 32'hAA);
        check("prio_cstore", bus.commit_store, 1);
        check("prio_cwb", bus.commit_wb, 0);

        // Query visibility of a same-cycle ALU result
        do_reset();
        for (int i = 0; i < 4; i++) alloc(i[4:0] + 5'd1, 1'b1, 1'b0, 1'b0);
        bus.q1_tag = 4'd3;
        bus.q2_tag = 4'd0;
        bus.alu_flag = 1'b1; bus.alu_reorder = 4'd3; bus.alu_val = 32'hABCD;
        #1;
`ifdef ROB_BYPASS_EN
        check("q_same_ready", bus.q1_ready, 1);
        check("q_same_val", bus.q1_val, 32'hABCD);
`else
        check("q_same_ready", bus.q1_ready, 0);
`endif
        tick();
        bus.alu_flag = 1'b0;
        #1;
        check("q_next_ready", bus.q1_ready, 1);
        check("q_next_val", bus.q1_val, 32'hABCD);
        check("q2_not_ready", bus.q2_ready, 0);

        // rdy low holds a ready head for 3 cycles
        bus.alu_flag = 1'b1; bus.alu_reorder = 4'd0; bus.alu_val = 32'h99;
        tick();
        bus.alu_flag = 1'b0;
        rdy = 1'b0;
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_cvalid", i), bus.commit_valid, 0);
            check($sformatf("hold%0d_tag", i), bus.alloc_tag, 4);
            check($sformatf("hold%0d_q2ready", i), bus.q2_ready, 1);
        end
        bus.alloc_valid = 1'b0;
        rdy = 1'b1;
        tick();
        check("resume_cvalid", bus.commit_valid, 1);
        check("resume_ctag", bus.commit_tag, 0);
        check("resume_cval", bus.commit_val, 32'h99);
        tick();
        check("resume_next", bus.commit_valid, 0);
        idle();

        // Mispredicted branch at tag 2 flushes younger tags 3..5
        do_reset();
        for (int i = 0; i < 6; i++) alloc(i[4:0] + 5'd8, 1'b1, 1'b0, (i == 2) ? 1'b1 : 1'b0);
        bus.alu_flag = 1'b1; bus.alu_reorder = 4'd0; bus.alu_val = 32'h1;
        bus.lsb_flag = 1'b1; bus.lsb_reorder = 4'd1; bus.lsb_val = 32'h2;
        tick();
        bus.alu_reorder = 4'd2; bus.alu_val = 32'h8;
        bus.alu_mispredict = 1'b1; bus.alu_target = 32'h1000;
        bus.lsb_reorder = 4'd3; bus.lsb_val = 32'h3;
        tick();
        check("br_c0_tag", bus.commit_tag, 0);
        check("br_c0_val", bus.commit_val, 32'h1);
        bus.alu_reorder = 4'd4; bus.alu_val = 32'h4; bus.alu_mispredict = 1'b0;
        bus.alu_target = 32'h0;
        bus.lsb_reorder = 4'd5; bus.lsb_val = 32'h5;
        tick();
        check("br_c1_tag", bus.commit_tag, 1);
        check("br_c1_val", bus.commit_val, 32'h2);
        check("br_c1_flush", bus.flush, 0);
        idle();
        bus.alloc_valid = 1'b1;
        tick();
        bus.alloc_valid = 1'b0;
        check("br_cvalid", bus.commit_valid, 1);
        check("br_ctag", bus.commit_tag, 2);
        check("br_flush", bus.flush, 1);
        check("br_flush_pc", bus.flush_pc, 32'h1000);
        check("br_alloc_tag", bus.alloc_tag, 0);
        check("br_full", bus.rob_full, 0);
        bus.q1_tag = 4'd3;
        tick();
        check("br_flush_pulse", bus.flush, 0);
        check("br_no_c3", bus.commit_valid, 0);
        check("br_q3_cleared", bus.q1_ready, 0);
        tick();
        check("br_no_c4", bus.commit_valid, 0);
        for (int i = 0; i < 15; i++) alloc(5'd1, 1'b1, 1'b0, 1'b0);
        check("br_cnt15_full", bus.rob_full, 0);
        alloc(5'd1, 1'b1, 1'b0, 1'b0);
        check("br_cnt16_full", bus.rob_full, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer.
- Allocates 4-bit reorder tags to instructions arriving from the decoder and supplies operand ready/value lookup to the reservation station at dispatch.
- Captures results from the ALU and LSB broadcast buses.
- Commits one instruction per cycle in order to the register file and the LSB store path. A mispredicted branch at commit flushes the pipeline.

Parameters:
- ROB_AW, 4, tag width; depth = 2**ROB_AW = 16 entries.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = hold all state
- alloc_valid  in  1  decoder requests an entry this cycle
- alloc_rd  in  5  destination register
- alloc_wb  in  1  instruction writes rd
- alloc_store  in  1  instruction is a store
- alloc_branch  in  1  instruction can mispredict
- rob_full  out  1  no free entry (combinational from count)
- alloc_tag  out  ROB_AW  tag for the current allocation (= tail)
- q1_tag, q2_tag  in  ROB_AW  operand producer tags queried at dispatch
- q1_ready, q2_ready  out  1  entry holds its result
- q1_val, q2_val  out  32  entry result
- alu_flag  in  1  ALU result valid
- alu_reorder  in  ROB_AW  ALU result tag
- alu_val  in  32  ALU result
- alu_mispredict  in  1  branch outcome differs from prediction
- alu_target  in  32  correct next PC
- lsb_flag  in  1  LSB result valid
- lsb_reorder  in  ROB_AW  LSB result tag
- lsb_val  in  32  LSB result
- commit_valid  out  1  one-cycle commit pulse
- commit_tag  out  ROB_AW  tag of the committed entry
- commit_rd  out  5  destination register
- commit_val  out  32  result
- commit_wb  out  1  register file write enable for this commit
- commit_store  out  1  tells the LSB to perform the store
- flush  out  1  one-cycle pipeline flush
- flush_pc  out  32  redirect PC

Behaviour:
- Reset: head = tail = count = 0; all busy and ready bits 0; every registered output 0.
- rdy low: no state change; commit_valid and flush drive 0.
- rob_full = (count == 16); alloc_tag = tail.
- Allocation:
  - When alloc_valid && !rob_full, the entry at tail is written with busy=1, ready=0 and the decode fields; tail increments mod 16.
  - alloc_valid while full is dropped; the decoder must hold it.
- Writeback:
  - alu_flag writes val, mispredict and target, and sets ready, only if the entry is busy and not yet ready. lsb_flag writes val and sets ready under the same condition.
  - Writes to a non-busy entry are ignored.
  - ALU and LSB writes to different tags in the same cycle both take effect.
  - Same tag on both buses in one cycle: the ALU write wins.
- Query:
  - q*_ready = busy && ready of the queried entry; q*_val = that entry's value.
  - Purely combinational on stored state unless ROB_BYPASS_EN is defined.
- Commit:
  - If the head entry is busy && ready, at the clock edge: commit_valid=1, fields copied to the commit outputs, commit_wb = wb flag, commit_store = store flag, busy cleared, head increments mod 16.
  - Otherwise commit_valid=0.
  - Latency is 1 cycle from the ready write to commit_valid when the entry is at head.
- Count update per cycle: +1 on allocation, -1 on commit. Allocation and commit in the same cycle leave count unchanged.
  - Full condition is evaluated on the pre-edge count, so a full buffer rejects allocation even in a cycle that commits.
- Flush:
  - Triggered when the committing entry has alloc_branch set and mispredict set.
  - On the same edge: commit pulse for that entry, flush=1, flush_pc = target, all busy bits cleared, head = tail = count = 0.
  - Allocation and writebacks arriving in that cycle are discarded.
  - flush lasts exactly one cycle.
- Wrap-around: pointers are ROB_AW bits and wrap naturally; count is ROB_AW+1 bits.

Optional Feature:
- Macro: ROB_BYPASS_EN.
- Defined: if q*_tag matches alu_reorder with alu_flag (or lsb_reorder with lsb_flag) in the current cycle and the entry is busy, q*_ready=1 and q*_val = bus value. ALU has priority over LSB.
- Undefined: the query sees stored state only; same-cycle results become visible the following cycle.

Test Plan:
- Reset, then 16 allocations with no writeback -> alloc_tag runs 0..15; rob_full=1 after the 16th; a 17th alloc_valid is dropped (tail stays 0).
- Allocate tags 0,1; lsb_flag tag 1 val 0x55, then alu_flag tag 0 val 0x11 -> commit tag 0 (val 0x11) on the edge after the ALU write, then tag 1 (val 0x55) the next cycle; strictly in order.
- Full buffer: commit at head plus alloc_valid in the same cycle -> no allocation that cycle, count 15; allocation succeeds the next cycle with alloc_tag = 0 (wrap).
- Branch at tag 2 with alu_mispredict=1, alu_target=0x1000, entries 3..5 younger -> commit tag 2 with flush=1 and flush_pc=0x1000; afterwards count=0, alloc_tag=0, and no commits for tags 3..5.
- q1_tag=3 while alu_flag writes tag 3 val 0xABCD -> with ROB_BYPASS_EN: q1_ready=1, q1_val=0xABCD in the same cycle; without it: q1_ready=0 that cycle and 1 the next.
- rdy held low 3 cycles with head ready -> no commit and no pointer change; commit occurs on the first edge after rdy returns high.
